// File: rtl/binary_tree_pkg.sv
// ---------------------------------------------------------------------------
// binary_tree_pkg
//
// Purpose:
//   Shared definitions for the binary splitter-tree valve sequencer:
//   the sequencer state encoding and the heap-order helpers that relate a
//   tree depth to its internal node count and a parent node to its children.
//
// Contents:
//   state_e     - sequencer states (IDLE, OPEN, HOLD, CLOSE)
//   childIndex  - heap index of the a-side (side=0) or b-side (side=1) child
//   nodeCount   - number of internal (valve-carrying) nodes for a depth
// ---------------------------------------------------------------------------
package binary_tree_pkg;

    // Sequencer states. IDLE is the only state that accepts a new request.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        HOLD  = 2'd2,
        CLOSE = 2'd3
    } state_e;

    // Heap numbering: root is 0, children of node i are 2i+1 (a) and 2i+2 (b).
    function automatic int childIndex(input int parent, input logic side);
        return (2 * parent) + 1 + (side ? 1 : 0);
    endfunction

    // A depth-d tree has 2**d outlets and 2**d - 1 internal branch nodes.
    function automatic int nodeCount(input int depth);
        return (1 << depth) - 1;
    endfunction

endpackage

// File: rtl/binary_tree_path_dec.sv
// ---------------------------------------------------------------------------
// binary_tree_path_dec
//
// Purpose:
//   Combinational root-to-leaf path decoder. For a destination outlet and a
//   tree level it returns the heap index of the path node at that level and
//   which branch (a = 0, b = 1) of that node leads toward the outlet.
//
// Ports:
//   dest_i   [DEPTH-1:0]  outlet index, MSB selects the branch at the root
//   level_i  [LVL_W-1:0]  tree level to decode (0 = root)
//   node_o   [NODE_W-1:0] heap index of the path node at level_i
//   side_o                branch taken at that node (0 = a, 1 = b)
//
//   Results are only meaningful for level_i < DEPTH.
// ---------------------------------------------------------------------------
module binary_tree_path_dec
    import binary_tree_pkg::*;
#(
    parameter int DEPTH  = 5,
    parameter int LVL_W  = $clog2(DEPTH + 1),
    parameter int NODE_W = DEPTH
)(
    input  logic [DEPTH-1:0]  dest_i,
    input  logic [LVL_W-1:0]  level_i,
    output logic [NODE_W-1:0] node_o,
    output logic              side_o
);

    int nodeIdx;

    // Walk down from the root, taking the branch named by each destination
    // bit above the requested level. The bit at the requested level itself
    // is the branch to open at that node.
    always_comb begin
        nodeIdx = 0;
        side_o  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == int'(level_i)) begin
                side_o = dest_i[DEPTH-1-k];
            end
            if (k < int'(level_i)) begin
                nodeIdx = childIndex(nodeIdx, dest_i[DEPTH-1-k]);
            end
        end
        node_o = NODE_W'(nodeIdx);
    end

endmodule

// File: rtl/binary_tree_split_ctrl.sv
// ---------------------------------------------------------------------------
// binary_tree_split_ctrl
//
// Purpose:
//   Valve sequencer for a depth-DEPTH binary splitter tree. A request routes
//   the source fluid to one of 2**DEPTH outlets: the branch valves along the
//   root-to-leaf path are opened one level at a time with SETTLE_CYC-cycle
//   gaps, the full path is held open for req_hold cycles, then every valve is
//   closed and, after a further SETTLE_CYC cycles, done pulses.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, closes all valves at once
//   req_valid  request present
//   req_ready  high only in IDLE; accept = req_valid && req_ready
//   req_dest   outlet index, MSB picks the branch at the root
//   req_hold   cycles the complete path stays open
//   abort      early close while opening or holding
//   valve_a    per heap node: a-side (left) valve open
//   valve_b    per heap node: b-side (right) valve open
//   busy       high whenever not IDLE
//   done       one-cycle pulse in the first IDLE cycle after a close
// ---------------------------------------------------------------------------
module binary_tree_split_ctrl
    import binary_tree_pkg::*;
#(
    parameter int DEPTH      = 5,
    parameter int SETTLE_CYC = 4,
    parameter int HOLD_W     = 16
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DEPTH-1:0]        req_dest,
    input  logic [HOLD_W-1:0]       req_hold,
    input  logic                    abort,
    output logic [(2**DEPTH)-2:0]   valve_a,
    output logic [(2**DEPTH)-2:0]   valve_b,
    output logic                    busy,
    output logic                    done
);

    localparam int N_NODES = nodeCount(DEPTH);
    localparam int SET_W   = $clog2(SETTLE_CYC + 1);
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int NODE_W  = DEPTH;

    // Settle counters count down from S-1 so a phase lasts exactly S cycles.
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [LVL_W-1:0] LAST_LEVEL  = LVL_W'(DEPTH - 1);

    state_e               state_q,     state_d;
    logic [LVL_W-1:0]     level_q,     level_d;
    logic [SET_W-1:0]     settleCnt_q, settleCnt_d;
    logic [HOLD_W-1:0]    holdCnt_q,   holdCnt_d;
    logic [DEPTH-1:0]     dest_q,      dest_d;
    logic [HOLD_W-1:0]    hold_q,      hold_d;
    logic [N_NODES-1:0]   valveA_q,    valveA_d;
    logic [N_NODES-1:0]   valveB_q,    valveB_d;
    logic                 done_q,      done_d;

    logic [DEPTH-1:0]     decDest;
    logic [LVL_W-1:0]     decLevel;
    logic [NODE_W-1:0]    decNode;
    logic                 decSide;
    logic [N_NODES-1:0]   nodeMask;
    logic [N_NODES-1:0]   openA;
    logic [N_NODES-1:0]   openB;

    // The single path decoder always looks one step ahead: in IDLE it decodes
    // level 0 of the incoming request so the root valve can open on the
    // accept edge; otherwise it decodes the next level of the captured path.
    always_comb begin
        if (state_q == IDLE) begin
            decDest  = req_dest;
            decLevel = '0;
        end else begin
            decDest  = dest_q;
            decLevel = level_q + LVL_W'(1);
        end
    end

    binary_tree_path_dec #(
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W),
        .NODE_W (NODE_W)
    ) u_pathDec (
        .dest_i  (decDest),
        .level_i (decLevel),
        .node_o  (decNode),
        .side_o  (decSide)
    );

    // One-hot valve set for the decoded node, split onto the a or b bank.
    always_comb begin
        nodeMask = N_NODES'(1) << decNode;
        openA    = decSide ? '0 : nodeMask;
        openB    = decSide ? nodeMask : '0;
    end

    // State register. Reset closes every valve immediately and suppresses
    // any pending done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            settleCnt_q <= '0;
            holdCnt_q   <= '0;
            dest_q      <= '0;
            hold_q      <= '0;
            valveA_q    <= '0;
            valveB_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            settleCnt_q <= settleCnt_d;
            holdCnt_q   <= holdCnt_d;
            dest_q      <= dest_d;
            hold_q      <= hold_d;
            valveA_q    <= valveA_d;
            valveB_q    <= valveB_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic. Valves only ever accumulate while opening and are
    // cleared together on the transition into CLOSE, so the outputs always
    // show a prefix of the path with at most one valve per node.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        settleCnt_d = settleCnt_q;
        holdCnt_d   = holdCnt_q;
        dest_d      = dest_q;
        hold_d      = hold_q;
        valveA_d    = valveA_q;
        valveB_d    = valveB_q;
        done_d      = 1'b0;

        case (state_q)
            // Accept opens the root valve right away; abort is ignored here,
            // including in the accept cycle.
            IDLE: begin
                if (req_valid) begin
                    state_d     = OPEN;
                    level_d     = '0;
                    settleCnt_d = SETTLE_LOAD;
                    dest_d      = req_dest;
                    hold_d      = req_hold;
                    valveA_d    = openA;
                    valveB_d    = openB;
                end
            end

            // Each level settles for SETTLE_CYC cycles before the next level
            // opens. A zero hold time skips HOLD entirely.
            OPEN: begin
                if (abort) begin
                    state_d     = CLOSE;
                    settleCnt_d = SETTLE_LOAD;
                    valveA_d    = '0;
                    valveB_d    = '0;
                end else if (settleCnt_q == '0) begin
                    if (level_q == LAST_LEVEL) begin
                        if (hold_q == '0) begin
                            state_d     = CLOSE;
                            settleCnt_d = SETTLE_LOAD;
                            valveA_d    = '0;
                            valveB_d    = '0;
                        end else begin
                            state_d   = HOLD;
                            holdCnt_d = hold_q - HOLD_W'(1);
                        end
                    end else begin
                        level_d     = level_q + LVL_W'(1);
                        settleCnt_d = SETTLE_LOAD;
                        valveA_d    = valveA_q | openA;
                        valveB_d    = valveB_q | openB;
                    end
                end else begin
                    settleCnt_d = settleCnt_q - SET_W'(1);
                end
            end

            // Full path open for exactly hold_q cycles.
            HOLD: begin
                if (abort || (holdCnt_q == '0)) begin
                    state_d     = CLOSE;
                    settleCnt_d = SETTLE_LOAD;
                    valveA_d    = '0;
                    valveB_d    = '0;
                end else begin
                    holdCnt_d = holdCnt_q - HOLD_W'(1);
                end
            end

            // Valves already closed; wait for the tree to settle, then report.
            CLOSE: begin
                if (settleCnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    settleCnt_d = settleCnt_q - SET_W'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                valveA_d = '0;
                valveB_d = '0;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign valve_a   = valveA_q;
    assign valve_b   = valveB_q;

endmodule
